// File: rtl/sru_dcs_cmd_queue.sv
// sru_dcs_cmd_queue: parses UDP command bytes into a command queue, issues them to the register bank, queues replies/timeouts, serves them as LocalLink frames
module sru_dcs_cmd_queue #(
  parameter logic [5:0] FIFO_ADDR = 6'd41,
  parameter int CMD_AW = 3,
  parameter int RPL_AW = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic gclk_40m,
  input  logic reset,
  input  logic [7:0] dcs_rxd,
  input  logic dcs_rx_dv,
  output logic udp_cmd_dv,
  output logic [AW-1:0] udp_cmd_addr,
  output logic [DW-1:0] udp_cmd_data,
  input  logic dcs_cmd_update,
  input  logic [AW+DW-1:0] dcs_cmd_reply,
  input  logic [5:0] dcs_rd_addr,
  output logic [7:0] dcs_rd_data_out,
  output logic dcs_rd_sof_n,
  output logic dcs_rd_eof_n,
  output logic dcs_rd_src_rdy_n,
  input  logic dcs_rd_dst_rdy_n,
  input  logic [15:0] dcs_udp_dst_port,
  input  logic [15:0] dcs_udp_src_port,
  output logic [3:0] dcs_rx_fifo_status,
  output logic dcs_rx_overflow,
  input  logic overflow_clr,
  output logic [7:0] timeout_cnt
);
  localparam int CW = AW + DW;
  localparam int NB = CW / 8;
  localparam int FL = NB + 4;
  localparam int PW = $clog2(NB + 1);
  localparam int FW = $clog2(FL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {I_IDLE, I_ISSUE, I_WAIT} ist_t;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_BODY} rd_t;
  ist_t ist, ist_n;
  rd_t rs, rs_n;
  logic [PW-1:0] cnt;
  logic [CW-1:0] sh;
  logic push_r;
  logic [CW-1:0] cmd_mem [2**CMD_AW];
  logic [CW-1:0] rpl_mem [2**RPL_AW];
  logic [CMD_AW:0] cwp, crp;
  logic [RPL_AW:0] rwp, rrp;
  logic cmd_empty, cmd_full, rpl_empty, rpl_full;
  logic cmd_push, cmd_pop, cmd_drop, rpl_push, rpl_pop, tmo_hit;
  logic [CW-1:0] rpl_din;
  logic [TW-1:0] tmr;
  logic [FW-1:0] fi;
  logic acc, last;
  logic [FL*8-1:0] fv, fs;
  assign cmd_empty = cwp == crp;
  assign cmd_full = (cwp ^ crp) == {1'b1, {CMD_AW{1'b0}}};
  assign rpl_empty = rwp == rrp;
  assign rpl_full = (rwp ^ rrp) == {1'b1, {RPL_AW{1'b0}}};
  // a pop in the same cycle frees the slot, so a push into a full queue still lands
  assign cmd_push = push_r && (!cmd_full || cmd_pop);
  assign cmd_drop = push_r && cmd_full && !cmd_pop;
  always_ff @(posedge gclk_40m or posedge reset)
    if (reset) begin
      cnt <= '0;
      sh <= '0;
      push_r <= 1'b0;
    end else begin
      push_r <= dcs_rx_dv && cnt == PW'(NB - 1);
      if (dcs_rx_dv) begin
        sh <= {sh[CW-9:0], dcs_rxd};
        cnt <= cnt == PW'(NB - 1) ? '0 : cnt + 1'b1;
      end else
        cnt <= '0;
    end
  always_ff @(posedge gclk_40m) begin
    if (cmd_push) cmd_mem[cwp[CMD_AW-1:0]] <= sh;
    if (rpl_push) rpl_mem[rwp[RPL_AW-1:0]] <= rpl_din;
  end
  always_ff @(posedge gclk_40m or posedge reset)
    if (reset) begin
      cwp <= '0;
      crp <= '0;
      rwp <= '0;
      rrp <= '0;
      dcs_rx_fifo_status <= 4'b0101;
      dcs_rx_overflow <= 1'b0;
    end else begin
      if (cmd_push) cwp <= cwp + 1'b1;
      if (cmd_pop) crp <= crp + 1'b1;
      if (rpl_push) rwp <= rwp + 1'b1;
      if (rpl_pop) rrp <= rrp + 1'b1;
      dcs_rx_fifo_status <= {rpl_full, rpl_empty, cmd_full, cmd_empty};
      dcs_rx_overflow <= cmd_drop ? 1'b1 : overflow_clr ? 1'b0 : dcs_rx_overflow;
    end
  // issue only with a free reply slot, so the WAIT push can never be lost
  always_comb begin
    ist_n = ist;
    cmd_pop = 1'b0;
    rpl_push = 1'b0;
    tmo_hit = 1'b0;
    rpl_din = dcs_cmd_reply;
    case (ist)
      I_IDLE: if (!cmd_empty && !rpl_full) begin
        ist_n = I_ISSUE;
        cmd_pop = 1'b1;
      end
      I_ISSUE: ist_n = I_WAIT;
      I_WAIT: if (dcs_cmd_update || tmr == TW'(TIMEOUT - 1)) begin
        ist_n = I_IDLE;
        rpl_push = 1'b1;
        tmo_hit = !dcs_cmd_update;
        rpl_din = dcs_cmd_update ? dcs_cmd_reply : {udp_cmd_addr, {DW{1'b1}}};
      end
      default: ist_n = I_IDLE;
    endcase
  end
  always_ff @(posedge gclk_40m or posedge reset)
    if (reset) begin
      ist <= I_IDLE;
      tmr <= '0;
      udp_cmd_addr <= '0;
      udp_cmd_data <= '0;
      timeout_cnt <= '0;
    end else begin
      ist <= ist_n;
      tmr <= ist == I_WAIT ? tmr + 1'b1 : '0;
      if (cmd_pop) {udp_cmd_addr, udp_cmd_data} <= cmd_mem[crp[CMD_AW-1:0]];
      if (tmo_hit && timeout_cnt != 8'hff) timeout_cnt <= timeout_cnt + 1'b1;
    end
  assign udp_cmd_dv = ist == I_ISSUE;
  assign acc = rs != R_IDLE && !dcs_rd_dst_rdy_n;
  assign last = fi == FW'(FL - 1);
  always_comb begin
    rs_n = rs;
    rpl_pop = 1'b0;
    case (rs)
      R_IDLE: if (dcs_rd_addr == FIFO_ADDR && !rpl_empty) rs_n = R_HDR;
      R_HDR: if (acc && fi == FW'(3)) rs_n = R_BODY;
      R_BODY: if (acc && last) begin
        rs_n = R_IDLE;
        rpl_pop = 1'b1;
      end
      default: rs_n = R_IDLE;
    endcase
  end
  always_ff @(posedge gclk_40m or posedge reset)
    if (reset) begin
      rs <= R_IDLE;
      fi <= '0;
    end else begin
      rs <= rs_n;
      fi <= rs == R_IDLE ? '0 : fi + FW'(acc);
    end
  // header and head reply as one vector; the current byte is its top byte after shifting by fi bytes
  assign fv = {dcs_udp_dst_port, dcs_udp_src_port, rpl_mem[rrp[RPL_AW-1:0]]};
  assign fs = fv << {fi, 3'b000};
  assign dcs_rd_data_out = rs == R_IDLE ? 8'h00 : fs[FL*8-1 -: 8];
  assign dcs_rd_src_rdy_n = rs == R_IDLE;
  assign dcs_rd_sof_n = !(rs == R_HDR && fi == '0);
  assign dcs_rd_eof_n = !(rs == R_BODY && last);
endmodule

// File: tb/tb_sru_dcs_cmd_queue.sv
// tb_sru_dcs_cmd_queue: randomized scenario bench with a queue-level reference model
module tb_sru_dcs_cmd_queue;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [7:0] rxd = 0;
  logic rx_dv = 0;
  logic cmd_dv;
  logic [31:0] cmd_addr, cmd_data;
  logic man_upd = 0, auto_upd = 0, upd;
  logic [63:0] man_rep = 0, auto_rep = 0, rep, pend_val = 0;
  logic [5:0] rd_addr = 0;
  logic [7:0] data_out;
  logic sof_n, eof_n, src_rdy_n;
  logic dst_rdy_n = 1;
  logic [15:0] dst_port = 16'h1234, src_port = 16'h5678;
  logic [3:0] status;
  logic ovf, ovf_clr = 0;
  logic [7:0] tcnt;
  int checks = 0, failures = 0, cyc = 0;
  logic auto_en = 0, auto_pend = 0;
  logic [63:0] issued_q[$];
  assign upd = man_upd | auto_upd;
  assign rep = auto_upd ? auto_rep : man_rep;

  sru_dcs_cmd_queue dut (
    .gclk_40m(clk), .reset(rst), .dcs_rxd(rxd), .dcs_rx_dv(rx_dv),
    .udp_cmd_dv(cmd_dv), .udp_cmd_addr(cmd_addr), .udp_cmd_data(cmd_data),
    .dcs_cmd_update(upd), .dcs_cmd_reply(rep), .dcs_rd_addr(rd_addr),
    .dcs_rd_data_out(data_out), .dcs_rd_sof_n(sof_n), .dcs_rd_eof_n(eof_n),
    .dcs_rd_src_rdy_n(src_rdy_n), .dcs_rd_dst_rdy_n(dst_rdy_n),
    .dcs_udp_dst_port(dst_port), .dcs_udp_src_port(src_port),
    .dcs_rx_fifo_status(status), .dcs_rx_overflow(ovf), .overflow_clr(ovf_clr),
    .timeout_cnt(tcnt));

  always @(posedge clk) cyc <= cyc + 1;

  // register-bank stand-in: answers every issued command one cycle later with {addr, ~data}
  always @(negedge clk) begin
    auto_upd <= auto_pend;
    if (auto_pend) auto_rep <= pend_val;
    auto_pend <= auto_en && cmd_dv;
    if (cmd_dv) pend_val <= {cmd_addr, ~cmd_data};
    if (cmd_dv) issued_q.push_back({cmd_addr, cmd_data});
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_bytes(input logic [7:0] b[$], output int last);
    foreach (b[i]) begin
      @(negedge clk);
      rx_dv = 1;
      rxd = b[i];
    end
    @(negedge clk);
    rx_dv = 0;
    rxd = 0;
    last = cyc;
  endtask

  task automatic add_word(inout logic [7:0] b[$], input logic [63:0] w);
    for (int k = 7; k >= 0; k--) b.push_back(w[k*8 +: 8]);
  endtask

  task automatic wait_issue(input int lim, output bit to, output logic [63:0] c, output int t);
    to = 1;
    c = '0;
    t = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (cmd_dv) begin
        to = 0;
        c = {cmd_addr, cmd_data};
        t = cyc;
        break;
      end
    end
  endtask

  // mode 0: always ready, 1: toggling, 2: random ready
  task automatic collect_frame(input int mode, input bit chg, output logic [95:0] v, output int n, output bit flags_ok);
    bit a;
    v = '0;
    n = 0;
    flags_ok = 1;
    rd_addr = 6'd41;
    for (int i = 0; i < 400 && n < 12; i++) begin
      @(negedge clk);
      dst_rdy_n = mode == 0 ? 1'b0 : mode == 1 ? 1'(i % 2) : 1'($urandom_range(0, 1));
      if (chg && n >= 3) rd_addr = 6'd5;
      a = !src_rdy_n && !dst_rdy_n;
      if (a) begin
        if (sof_n !== (n != 0) || eof_n !== (n != 11)) flags_ok = 0;
        v = {v[87:0], data_out};
        n++;
      end
    end
    @(negedge clk);
    rd_addr = 0;
    dst_rdy_n = 1;
  endtask

  task automatic test_reset;
    checks++;
    if (status !== 4'b0101) begin failures++; $display("FAIL reset_status: got %b exp 0101", status); end
    checks++;
    if ({src_rdy_n, sof_n, eof_n} !== 3'b111) begin failures++; $display("FAIL reset_rd_ctl: got %b exp 111", {src_rdy_n, sof_n, eof_n}); end
    checks++;
    if ({cmd_dv, ovf, tcnt, data_out, cmd_addr, cmd_data} !== '0) begin failures++; $display("FAIL reset_zero: dv=%b ovf=%b tcnt=%h dout=%h addr=%h data=%h exp all 0", cmd_dv, ovf, tcnt, data_out, cmd_addr, cmd_data); end
  endtask

  task automatic test_single;
    logic [7:0] b[$];
    logic [63:0] c;
    logic [95:0] v;
    int last, t, n;
    bit to, fok;
    add_word(b, 64'h00000010_12345678);
    send_bytes(b, last);
    wait_issue(10, to, c, t);
    checks++;
    if (to || t != last + 2) begin failures++; $display("FAIL single_latency: got cycle %0d (timeout=%b) exp %0d", t, to, last + 2); end
    checks++;
    if (c !== 64'h00000010_12345678) begin failures++; $display("FAIL single_cmd: got %h exp 0000001012345678", c); end
    @(negedge clk);
    checks++;
    if (cmd_dv !== 1'b0) begin failures++; $display("FAIL single_dv_width: got %b exp 0", cmd_dv); end
    man_upd = 1;
    man_rep = 64'h00000010_CAFEBABE;
    @(negedge clk);
    man_upd = 0;
    collect_frame(0, 0, v, n, fok);
    checks++;
    if (n != 12 || v !== {dst_port, src_port, 64'h00000010_CAFEBABE} || !fok) begin
      failures++; $display("FAIL single_frame: got %h n=%0d flags=%b exp %h", v, n, fok, {dst_port, src_port, 64'h00000010_CAFEBABE});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (status !== 4'b0101) begin failures++; $display("FAIL single_status: got %b exp 0101", status); end
  endtask

  task automatic test_random;
    logic [7:0] b[$];
    logic [63:0] w, c;
    logic [95:0] v;
    int last, t, n;
    bit to, fok;
    auto_en = 1;
    for (int it = 0; it < 6; it++) begin
      b = {};
      w = {$urandom, $urandom};
      dst_port = 16'($urandom);
      src_port = 16'($urandom);
      add_word(b, w);
      send_bytes(b, last);
      wait_issue(10, to, c, t);
      checks++;
      if (to || c !== w) begin failures++; $display("FAIL random_cmd%0d: got %h (timeout=%b) exp %h", it, c, to, w); end
      collect_frame(2, 0, v, n, fok);
      checks++;
      if (n != 12 || v !== {dst_port, src_port, w[63:32], ~w[31:0]} || !fok) begin
        failures++; $display("FAIL random_frame%0d: got %h n=%0d flags=%b exp %h", it, v, n, fok, {dst_port, src_port, w[63:32], ~w[31:0]});
      end
    end
  endtask

  task automatic test_burst20;
    logic [7:0] b[$];
    logic [63:0] w0, w1;
    logic [95:0] v;
    int last, n, base;
    bit fok;
    auto_en = 1;
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    add_word(b, w0);
    add_word(b, w1);
    for (int k = 0; k < 4; k++) b.push_back(8'($urandom));
    base = issued_q.size();
    send_bytes(b, last);
    repeat (20) @(negedge clk);
    checks++;
    if (issued_q.size() - base != 2) begin failures++; $display("FAIL burst_count: got %0d exp 2", issued_q.size() - base); end
    else begin
      checks++;
      if (issued_q[base] !== w0 || issued_q[base + 1] !== w1) begin
        failures++; $display("FAIL burst_order: got %h %h exp %h %h", issued_q[base], issued_q[base + 1], w0, w1);
      end
    end
    checks++;
    if (status[0] !== 1'b1) begin failures++; $display("FAIL burst_cmd_empty: got %b exp 1", status[0]); end
    collect_frame(0, 0, v, n, fok);
    checks++;
    if (n != 12 || v !== {dst_port, src_port, w0[63:32], ~w0[31:0]} || !fok) begin failures++; $display("FAIL burst_frame0: got %h n=%0d exp %h", v, n, {dst_port, src_port, w0[63:32], ~w0[31:0]}); end
    collect_frame(0, 0, v, n, fok);
    checks++;
    if (n != 12 || v !== {dst_port, src_port, w1[63:32], ~w1[31:0]} || !fok) begin failures++; $display("FAIL burst_frame1: got %h n=%0d exp %h", v, n, {dst_port, src_port, w1[63:32], ~w1[31:0]}); end
  endtask

  task automatic test_fill_overflow;
    logic [7:0] b[$];
    logic [63:0] w, exp_rpl[$];
    logic [95:0] v, e;
    int last, n, base;
    bit fok;
    auto_en = 1;
    rd_addr = 0;
    base = issued_q.size();
    for (int k = 0; k < 8; k++) begin
      w = {$urandom, $urandom};
      add_word(b, w);
      exp_rpl.push_back({w[63:32], ~w[31:0]});
    end
    send_bytes(b, last);
    repeat (10) @(negedge clk);
    checks++;
    if (status !== 4'b1001 || issued_q.size() - base != 8) begin failures++; $display("FAIL fill_rpl_full: got status %b issued %0d exp 1001 issued 8", status, issued_q.size() - base); end
    b = {};
    for (int k = 0; k < 9; k++) begin
      w = {$urandom, $urandom};
      add_word(b, w);
      if (k < 8) exp_rpl.push_back({w[63:32], ~w[31:0]});
    end
    send_bytes(b, last);
    repeat (20) @(negedge clk);
    checks++;
    if (issued_q.size() - base != 8) begin failures++; $display("FAIL stall_no_issue: got %0d issued exp 8", issued_q.size() - base); end
    checks++;
    if (status !== 4'b1010 || ovf !== 1'b1) begin failures++; $display("FAIL overflow_set: got status %b ovf %b exp 1010 ovf 1", status, ovf); end
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL overflow_clr: got %b exp 0", ovf); end
    for (int f = 0; f < 16; f++) begin
      collect_frame(f % 3, 0, v, n, fok);
      e = {dst_port, src_port, exp_rpl[f]};
      checks++;
      if (n != 12 || v !== e || !fok) begin failures++; $display("FAIL fill_frame%0d: got %h n=%0d flags=%b exp %h", f, v, n, fok, e); end
      if (f == 0) begin
        repeat (6) @(negedge clk);
        checks++;
        if (issued_q.size() - base != 9) begin failures++; $display("FAIL stall_release: got %0d issued exp 9", issued_q.size() - base); end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (status !== 4'b0101 || issued_q.size() - base != 16) begin failures++; $display("FAIL fill_drain: got status %b issued %0d exp 0101 issued 16", status, issued_q.size() - base); end
  endtask

  task automatic test_timeout;
    logic [7:0] b[$];
    logic [63:0] w, c;
    logic [95:0] v;
    int last, t, n, tt;
    bit to, fok;
    auto_en = 0;
    @(negedge clk);
    man_upd = 1;
    man_rep = {$urandom, $urandom};
    @(negedge clk);
    man_upd = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (status !== 4'b0101) begin failures++; $display("FAIL idle_update_ignored: got status %b exp 0101", status); end
    w = {$urandom, $urandom};
    add_word(b, w);
    send_bytes(b, last);
    wait_issue(10, to, c, t);
    tt = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (tcnt == 8'd1) begin tt = cyc; break; end
    end
    checks++;
    if (to || tt != t + 1024) begin failures++; $display("FAIL timeout_time: got cycle %0d exp %0d", tt, t + 1024); end
    collect_frame(0, 0, v, n, fok);
    checks++;
    if (n != 12 || v !== {dst_port, src_port, w[63:32], 32'hFFFFFFFF} || !fok) begin failures++; $display("FAIL timeout_frame: got %h n=%0d exp %h", v, n, {dst_port, src_port, w[63:32], 32'hFFFFFFFF}); end
    checks++;
    if (tcnt !== 8'd1) begin failures++; $display("FAIL timeout_cnt: got %0d exp 1", tcnt); end
  endtask

  task automatic test_stress_frame;
    logic [7:0] b[$];
    logic [63:0] w;
    logic [95:0] v;
    int last, n;
    bit fok;
    auto_en = 1;
    w = {$urandom, $urandom};
    add_word(b, w);
    send_bytes(b, last);
    repeat (8) @(negedge clk);
    collect_frame(1, 1, v, n, fok);
    checks++;
    if (n != 12 || v !== {dst_port, src_port, w[63:32], ~w[31:0]} || !fok) begin failures++; $display("FAIL stress_frame: got %h n=%0d flags=%b exp %h", v, n, fok, {dst_port, src_port, w[63:32], ~w[31:0]}); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b[$];
    int last;
    auto_en = 1;
    add_word(b, {$urandom, $urandom});
    send_bytes(b, last);
    repeat (8) @(negedge clk);
    rd_addr = 6'd41;
    dst_rdy_n = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (src_rdy_n !== 1'b0) begin failures++; $display("FAIL midframe_active: got src_rdy_n %b exp 0", src_rdy_n); end
    #2 rst = 1;
    #1;
    checks++;
    if ({src_rdy_n, sof_n, eof_n} !== 3'b111 || status !== 4'b0101 || tcnt !== 8'd0) begin
      failures++; $display("FAIL midframe_reset: got rd_ctl %b status %b tcnt %0d exp 111 0101 0", {src_rdy_n, sof_n, eof_n}, status, tcnt);
    end
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (src_rdy_n !== 1'b1 || cmd_dv !== 1'b0 || status !== 4'b0101) begin failures++; $display("FAIL reset_residue: got src_rdy_n %b dv %b status %b exp 1 0 0101", src_rdy_n, cmd_dv, status); end
    rd_addr = 0;
    dst_rdy_n = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 0;
    @(negedge clk);
    test_single;
    test_random;
    test_burst20;
    test_fill_overflow;
    test_timeout;
    test_stress_frame;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sru_dcs_cmd_queue.md
Name: sru_dcs_cmd_queue

Overview:
Parametrised successor to the SRU DCS FIFO path: parses UDP command bytes into {addr,data} words, queues up to 2^CMD_AW commands, and issues them one at a time to the register bank. Collects each reply, or a timeout reply, into a 2^RPL_AW-deep reply queue. Serves the replies as LocalLink byte frames to the DCS reader. The block is single-clock: the RX byte stream is already in the gclk_40m domain.

Parameters:
FIFO_ADDR, 6'd41, reader address this block answers on
CMD_AW, 3, log2 command-queue depth
RPL_AW, 3, log2 reply-queue depth
AW, 32, command address width (multiple of 8)
DW, 32, command data width (multiple of 8)
TIMEOUT, 1023, cycles to wait for dcs_cmd_update before a timeout reply is generated

Ports:
gclk_40m  in  1  sole clock
reset  in  1  asynchronous, active-high reset
dcs_rxd  in  8  command byte
dcs_rx_dv  in  1  byte valid; high for the whole UDP payload burst
udp_cmd_dv  out  1  one-cycle command strobe
udp_cmd_addr  out  AW  command address
udp_cmd_data  out  DW  command data
dcs_cmd_update  in  1  one-cycle reply valid
dcs_cmd_reply  in  AW+DW  reply word
dcs_rd_addr  in  6  reader select
dcs_rd_data_out  out  8  frame byte
dcs_rd_sof_n / dcs_rd_eof_n  out  1 each  frame delimiters, active-low
dcs_rd_src_rdy_n  out  1  byte valid, active-low
dcs_rd_dst_rdy_n  in  1  reader ready, active-low
dcs_udp_dst_port, dcs_udp_src_port  in  16 each  header fields
dcs_rx_fifo_status  out  4  {rpl_full, rpl_empty, cmd_full, cmd_empty}
dcs_rx_overflow  out  1  sticky command-drop flag
overflow_clr  in  1  clears dcs_rx_overflow
timeout_cnt  out  8  saturating count of timeout replies

Behaviour:
- Reset values: all outputs 0, except dcs_rd_sof_n, dcs_rd_eof_n and dcs_rd_src_rdy_n = 1, and status = 4'b0101. Both queues are emptied and all FSMs go to IDLE. Asserting reset mid-frame or mid-command aborts the operation with no residue.
- Parser:
  - A byte counter runs while dcs_rx_dv is high. Bytes are assembled MSB-first: the first AW/8 bytes form addr, the next DW/8 form data.
  - When the final byte of a command arrives, the command is pushed the next cycle and the counter wraps to 0, so several commands per burst are allowed.
  - When dv falls, the counter resets and any partial command is discarded.
  - A push while cmd_full drops the command and sets dcs_rx_overflow. overflow_clr clears the flag; if a drop and overflow_clr occur in the same cycle, set wins.
- Issue FSM (IDLE -> ISSUE -> WAIT -> IDLE):
  - IDLE -> ISSUE when the command queue is non-empty and the reply queue has a free slot. If rpl_full, the block stalls and never drops a reply.
  - ISSUE: pop the command and drive udp_cmd_dv high for exactly one cycle with addr/data. addr/data hold until the next issue.
  - WAIT: dcs_cmd_update pushes dcs_cmd_reply into the reply queue. If TIMEOUT cycles elapse with no update, push {addr, {DW{1'b1}}} and increment timeout_cnt (saturates at 255).
  - Updates arriving outside WAIT are ignored. An update in the same cycle as timeout expiry counts as a reply, not a timeout.
  - Minimum latency: final command byte at cycle N -> udp_cmd_dv at N+2.
- Read FSM (IDLE -> HDR -> BODY):
  - A frame starts when dcs_rd_addr == FIFO_ADDR and the reply queue is non-empty. dcs_rd_addr is sampled only at frame start; later changes do not abort the frame.
  - Frame = 4 header bytes (dst_port MSB, dst LSB, src MSB, src LSB) followed by (AW+DW)/8 reply bytes, MSB-first.
  - src_rdy_n is low for every byte of the frame. A byte advances only when src_rdy_n and dst_rdy_n are both low.
  - sof_n is low with the first header byte; eof_n is low with the last reply byte.
  - The reply entry is popped on acceptance of the eof byte. Back-to-back frames are allowed, with one idle cycle between them.
- Status bits are registered, updated one cycle after a push or pop. Pointers are CMD_AW+1 / RPL_AW+1 bits wide, with wrap-around via the MSB compare.
- Simultaneous push and pop on either queue in the same cycle is legal, including when full or empty as seen before the pop.

Test Plan:
1. One 8-byte burst 00 00 00 10 12 34 56 78 -> udp_cmd_dv at N+2 with addr 0x10 and data 0x12345678. Then update with reply 0x00000010_CAFEBABE and rd_addr=41, dst_rdy_n=0 -> 12-byte frame: port bytes, then 00 00 00 10 CA FE BA BE; sof_n on byte 0, eof_n on byte 11.
2. A 20-byte burst -> two commands issued in order; the trailing 4 bytes are discarded; cmd_empty returns to 1.
3. 9 commands with no replies (depth 8) -> 8 queued, the 9th dropped, dcs_rx_overflow=1. overflow_clr clears it.
4. No dcs_cmd_update -> after 1023 cycles a reply with data 0xFFFFFFFF is queued and timeout_cnt=1.
5. Fill the reply queue (8 entries), then enqueue a command -> no udp_cmd_dv until one frame is read out, then it issues.
6. dst_rdy_n toggled every cycle mid-frame, and rd_addr changed to 5 mid-frame -> frame completes with all 12 bytes in order. Reset asserted mid-frame -> src_rdy_n=1 immediately and status=0101.
